bus_slave_if: RTL

- Slave-side responder for the shared 30-bit word-address bus, facing the CPU bus master interface.
- Accepts a one-cycle address strobe from the granted master and forwards the access to a simple peripheral register port.
- Inserts programmable wait states and returns one `rdy_` pulse with read data.
- Sits between the bus slave multiplexer/decoder and each peripheral (timer, UART, GPIO); a non-responding peripheral is caught by a timeout.

---
 rtl/bus_slave_if_pkg.sv | 28 ++
 rtl/bus_slave_if.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/bus_slave_if_pkg.sv
// Shared bus definitions for the 30-bit word-address slave interface.
package bus_slave_if_pkg;

  localparam int unsigned WORD_ADDR_W      = 30;
  localparam int unsigned WORD_DATA_W      = 32;
  // First word-address bit of the slave index field used by the external decoder
  localparam int unsigned BusSlaveIndexLoc = 27;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [1:0] {
    BUS_SLAVE_STATE_IDLE = 2'd0,
    BUS_SLAVE_STATE_WAIT = 2'd1,
    BUS_SLAVE_STATE_DEV  = 2'd2,
    BUS_SLAVE_STATE_RESP = 2'd3
  } bus_slave_state_e;

  typedef struct packed {
    logic                   rw;
    logic [WORD_DATA_W-1:0] data;
  } bus_xfer_t;

  localparam bus_xfer_t XFER_RST = '{rw: READ, data: '0};

endpackage

// File: rtl/bus_slave_if.sv
// Slave-side responder: accepts a strobed access, inserts wait states, drives a
// peripheral register port and returns one rdy_ pulse (or a timeout error).
module bus_slave_if
  import bus_slave_if_pkg::*;
#(
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cs_,
  input  logic                   as_,
  input  logic [WORD_ADDR_W-1:0] addr,
  input  logic                   rw,
  input  logic [WORD_DATA_W-1:0] wr_data,
  output logic                   rdy_,
  output logic [WORD_DATA_W-1:0] rd_data,
  output logic                   dev_req_,
  output logic [ADDR_W-1:0]      dev_addr,
  output logic                   dev_rw,
  output logic [WORD_DATA_W-1:0] dev_wr_data,
  input  logic [WORD_DATA_W-1:0] dev_rd_data,
  input  logic                   dev_ack_,
  output logic                   err,
  input  logic                   err_clr
);

  localparam int unsigned WCNT_W = 4;
  localparam int unsigned TCNT_W = 8;
  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(WAIT_CYCLES);
  localparam logic [TCNT_W-1:0] TMO_LIMIT = TCNT_W'(TIMEOUT);

  bus_slave_state_e       state_q, state_d;
  logic [WCNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [TCNT_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic                   rdy_q, rdy_d;
  logic [WORD_DATA_W-1:0] rd_data_q, rd_data_d;
  logic                   dev_req_q, dev_req_d;
  logic [ADDR_W-1:0]      dev_addr_q, dev_addr_d;
  bus_xfer_t              xfer_q, xfer_d;
  logic                   err_q, err_d;

  // Only the local register offset reaches the peripheral
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[WORD_ADDR_W-1:ADDR_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BUS_SLAVE_STATE_IDLE;
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      rdy_q      <= DISABLE_;
      rd_data_q  <= '0;
      dev_req_q  <= DISABLE_;
      dev_addr_q <= '0;
      xfer_q     <= XFER_RST;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      rdy_q      <= rdy_d;
      rd_data_q  <= rd_data_d;
      dev_req_q  <= dev_req_d;
      dev_addr_q <= dev_addr_d;
      xfer_q     <= xfer_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    rdy_d      = rdy_q;
    rd_data_d  = rd_data_q;
    dev_req_d  = dev_req_q;
    dev_addr_d = dev_addr_q;
    xfer_d     = xfer_q;
    // A timeout below overrides a same-edge clear
    err_d      = err_q & ~err_clr;

    unique case (state_q)
      BUS_SLAVE_STATE_IDLE: begin
        if (cs_ == ENABLE_ && as_ == ENABLE_) begin
          dev_addr_d  = addr[ADDR_W-1:0];
          xfer_d.rw   = rw;
          xfer_d.data = wr_data;
          wait_cnt_d  = WAIT_LOAD;
          tmo_cnt_d   = '0;
          if (WAIT_CYCLES != 0) begin
            state_d = BUS_SLAVE_STATE_WAIT;
          end else begin
            state_d   = BUS_SLAVE_STATE_DEV;
            dev_req_d = ENABLE_;
          end
        end
      end
      BUS_SLAVE_STATE_WAIT: begin
        wait_cnt_d = wait_cnt_q - WCNT_W'(1);
        if (wait_cnt_q == WCNT_W'(1)) begin
          state_d   = BUS_SLAVE_STATE_DEV;
          dev_req_d = ENABLE_;
          tmo_cnt_d = '0;
        end
      end
      BUS_SLAVE_STATE_DEV: begin
        if (dev_ack_ == ENABLE_) begin
          rd_data_d = (xfer_q.rw == READ) ? dev_rd_data : '0;
          rdy_d     = ENABLE_;
          dev_req_d = DISABLE_;
          state_d   = BUS_SLAVE_STATE_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TCNT_W'(1);
          if (tmo_cnt_q + TCNT_W'(1) == TMO_LIMIT) begin
            err_d     = 1'b1;
            rd_data_d = '0;
            rdy_d     = ENABLE_;
            dev_req_d = DISABLE_;
            state_d   = BUS_SLAVE_STATE_RESP;
          end
        end
      end
      BUS_SLAVE_STATE_RESP: begin
        rdy_d      = DISABLE_;
        rd_data_d  = '0;
        dev_addr_d = '0;
        xfer_d     = XFER_RST;
        state_d    = BUS_SLAVE_STATE_IDLE;
      end
      default: state_d = BUS_SLAVE_STATE_IDLE;
    endcase
  end

  assign rdy_        = rdy_q;
  assign rd_data     = rd_data_q;
  assign dev_req_    = dev_req_q;
  assign dev_addr    = dev_addr_q;
  assign dev_rw      = xfer_q.rw;
  assign dev_wr_data = xfer_q.data;
  assign err         = err_q;

endmodule
